ibex_pext_mc_ctrl: RTL

//  Issue-side controller for ibex_alu_pext. Accepts one P-ext/multdiv request on a valid/ready

---
 rtl/ibex_pext_mc_ctrl.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/ibex_pext_mc_ctrl.sv
// ibex_pext_mc_ctrl: issue-side controller for ibex_alu_pext.
// Takes one P-ext/multdiv request, holds operands to the ALU, owns the two
// 34-bit intermediate registers, and returns the captured result on a
// valid/ready response port. Keeps a sticky saturation flag.
// Optional feature macro: PEXT_MC_WATCHDOG_EN (EXEC-cycle watchdog, MAX_CYCLES).
module ibex_pext_mc_ctrl
`ifdef PEXT_MC_WATCHDOG_EN
#(
   parameter int unsigned MAX_CYCLES = 40
)
`endif
(
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic [31:0] req_op_a_i,
   input  logic [31:0] req_op_b_i,
   input  logic [31:0] req_op_rd_i,
   input  logic        req_mult_i,
   input  logic        req_div_i,
   output logic [31:0] alu_op_a_o,
   output logic [31:0] alu_op_b_o,
   output logic [31:0] alu_op_rd_o,
   output logic        alu_mult_en_o,
   output logic        alu_div_en_o,
   output logic        alu_md_ready_o,
   output logic [33:0] imd_val_q0_o,
   output logic [33:0] imd_val_q1_o,
   input  logic [33:0] imd_val_d0_i,
   input  logic [33:0] imd_val_d1_i,
   input  logic [1:0]  imd_val_we_i,
   input  logic [31:0] alu_result_i,
   input  logic        alu_valid_i,
   input  logic        alu_set_ov_i,
   output logic        rsp_valid_o,
   input  logic        rsp_ready_i,
   output logic [31:0] rsp_result_o,
   output logic        rsp_ov_o,
   output logic        rsp_err_o,
   output logic        ov_sticky_o,
   input  logic        ov_clr_i
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

   state_e      state_q, state_d;
   logic        accept, capture, timeout;
   logic        mult_q, div_q;

   // Ready is gated by reset so every output reads 0 while rst_ni is low.
   assign req_ready_o = rst_ni & ((state_q == IDLE) | ((state_q == RESP) & rsp_ready_i));
   assign accept      = req_valid_i & req_ready_o;
   assign capture     = (state_q == EXEC) & alu_valid_i;

`ifdef PEXT_MC_WATCHDOG_EN
   logic [7:0] cnt_q;
   logic       err_q;

   assign timeout   = (state_q == EXEC) & ~alu_valid_i & (cnt_q == 8'(MAX_CYCLES - 1));
   assign rsp_err_o = err_q;

   // EXEC cycle counter; zero outside EXEC so it is clear on every entry
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)                cnt_q <= '0;
      else if (state_q != EXEC)   cnt_q <= '0;
      else                        cnt_q <= cnt_q + 8'd1;
   end

   // Error flag of the held response
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)       err_q <= 1'b0;
      else if (capture)  err_q <= 1'b0;
      else if (timeout)  err_q <= 1'b1;
   end
`else
   assign timeout   = 1'b0;
   assign rsp_err_o = 1'b0;
`endif

   // State register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= IDLE;
      else         state_q <= state_d;
   end

   // Next state and ALU/response handshake outputs
   always_comb begin
      state_d        = state_q;
      alu_mult_en_o  = 1'b0;
      alu_div_en_o   = 1'b0;
      alu_md_ready_o = 1'b0;
      rsp_valid_o    = 1'b0;
      unique case (state_q)
         IDLE: if (accept) state_d = EXEC;
         EXEC: begin
            alu_mult_en_o  = mult_q;
            alu_div_en_o   = div_q;
            alu_md_ready_o = 1'b1;
            if (capture || timeout) state_d = RESP;
         end
         RESP: begin
            rsp_valid_o = 1'b1;
            if (rsp_ready_i) state_d = accept ? EXEC : IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Operand and op-type latches, loaded on request accept
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         alu_op_a_o  <= '0;
         alu_op_b_o  <= '0;
         alu_op_rd_o <= '0;
         mult_q      <= 1'b0;
         div_q       <= 1'b0;
      end else if (accept) begin
         alu_op_a_o  <= req_op_a_i;
         alu_op_b_o  <= req_op_b_i;
         alu_op_rd_o <= req_op_rd_i;
         mult_q      <= req_mult_i & ~req_div_i;
         div_q       <= req_div_i;
      end
   end

   // Intermediate registers: cleared on accept, written by the ALU only in EXEC
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         imd_val_q0_o <= '0;
         imd_val_q1_o <= '0;
      end else if (accept) begin
         imd_val_q0_o <= '0;
         imd_val_q1_o <= '0;
      end else if (state_q == EXEC) begin
         if (imd_val_we_i[0]) imd_val_q0_o <= imd_val_d0_i;
         if (imd_val_we_i[1]) imd_val_q1_o <= imd_val_d1_i;
      end
   end

   // Response data capture; a watchdog expiry returns zero data
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rsp_result_o <= '0;
         rsp_ov_o     <= 1'b0;
      end else if (capture) begin
         rsp_result_o <= alu_result_i;
         rsp_ov_o     <= alu_set_ov_i;
      end else if (timeout) begin
         rsp_result_o <= '0;
         rsp_ov_o     <= 1'b0;
      end
   end

   // Sticky saturation flag; a capture with set_ov wins over a clear
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)                        ov_sticky_o <= 1'b0;
      else if (capture && alu_set_ov_i)   ov_sticky_o <= 1'b1;
      else if (ov_clr_i)                  ov_sticky_o <= 1'b0;
   end

endmodule
